// File: rtl/occ_grid_pkg.sv
// Shared types, sizes and saturating arithmetic for the occupancy grid updater.
// Map geometry and log-odds update constants live here so the top and the RAM
// agree on widths. The optional OCC_STATS_EN build uses sat_clamps() as well.
package occ_grid_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int LO_W     = 8;
    localparam int HIT_INC  = 7;
    localparam int MISS_DEC = 2;
    localparam int LO_MAX   = 100;
    localparam int LO_MIN   = -100;

    localparam int ADDR_W = X_W + Y_W;
    localparam int CELLS  = 2 ** ADDR_W;

    typedef logic signed [LO_W-1:0] log_odds_t;
    typedef logic [ADDR_W-1:0]      cell_addr_t;

    typedef enum logic [1:0] {CLEAR, RUN, DRAIN} occ_state_e;

    // Constants widened by one bit so the sum can never overflow before clamping.
    localparam logic signed [LO_W:0] INC_W = (LO_W+1)'(HIT_INC);
    localparam logic signed [LO_W:0] DEC_W = (LO_W+1)'(MISS_DEC);
    localparam logic signed [LO_W:0] MAX_W = (LO_W+1)'(LO_MAX);
    localparam logic signed [LO_W:0] MIN_W = (LO_W+1)'(LO_MIN);

    // Unclamped one-bit-wider result of applying a hit or a free update.
    function automatic logic signed [LO_W:0] raw_sum(input log_odds_t old, input logic hit);
        logic signed [LO_W:0] oldWide;
        oldWide = (LO_W+1)'(old);
        if (hit) begin
            return oldWide + INC_W;
        end
        return oldWide - DEC_W;
    endfunction

    // New cell value after one update, held inside [LO_MIN, LO_MAX].
    function automatic log_odds_t sat_add(input log_odds_t old, input logic hit);
        logic signed [LO_W:0] sum;
        sum = raw_sum(old, hit);
        if (sum > MAX_W) begin
            return MAX_W[LO_W-1:0];
        end
        if (sum < MIN_W) begin
            return MIN_W[LO_W-1:0];
        end
        return sum[LO_W-1:0];
    endfunction

    // True when the update would have left the legal range and got pinned at a bound.
    function automatic logic sat_clamps(input log_odds_t old, input logic hit);
        logic signed [LO_W:0] sum;
        sum = raw_sum(old, hit);
        return (sum > MAX_W) || (sum < MIN_W);
    endfunction

endpackage

// File: rtl/occ_grid_ram.sv
// Simple dual-port log-odds map: one synchronous read port, one write port.
// The read returns the value held before any write on the same edge; the top
// handles same-address forwarding. Contents are not reset.
module occ_grid_ram
    import occ_grid_pkg::*;
(
    input  logic       clock,
    input  cell_addr_t rd_addr_i,
    output log_odds_t  rd_data_o,
    input  logic       wr_en_i,
    input  cell_addr_t wr_addr_i,
    input  log_odds_t  wr_data_i
);

    log_odds_t mem_q [CELLS];

    // Write port: store one cell per cycle when enabled.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port: registered read of the old contents.
    always_ff @(posedge clock) begin
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/occupancy_grid_updater.sv
// Log-odds occupancy map owner: clears the map after reset, then applies one
// saturating read-modify-write per accepted ray cell and serves map reads.
// Optional feature macro: OCC_STATS_EN adds stat_updates / stat_sat counters.
module occupancy_grid_updater
    import occ_grid_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cell_valid,
    output logic             cell_ready,
    input  logic [X_W-1:0]   cell_x,
    input  logic [Y_W-1:0]   cell_y,
    input  logic             cell_hit,
    input  logic             rd_en,
    input  logic [X_W-1:0]   rd_x,
    input  logic [Y_W-1:0]   rd_y,
    output logic             rd_valid,
    output log_odds_t        rd_data,
    output logic             busy
`ifdef OCC_STATS_EN
    ,
    output logic [31:0]      stat_updates,
    output logic [31:0]      stat_sat
`endif
);

    occ_state_e state_q, state_d;
    cell_addr_t clrAddr_q;

    logic       s1Valid_q;
    cell_addr_t s1Addr_q;
    logic       s1Hit_q;

    logic       wrValid_q;
    cell_addr_t wrAddr_q;
    log_odds_t  wrData_q;

    logic       rdValid_q;
    cell_addr_t rdAddr_q;

    logic       clearReq;
    logic       accept;
    cell_addr_t ramRdAddr;
    log_odds_t  ramRdData;
    log_odds_t  oldVal;
    log_odds_t  newVal;
    logic       wrEn;
    cell_addr_t wrAddr;
    log_odds_t  wrData;

    // No runtime clear request exists yet; DRAIN is kept ready for one.
    assign clearReq = 1'b0;

    assign accept    = cell_valid & cell_ready;
    assign ramRdAddr = rd_en ? {rd_y, rd_x} : {cell_y, cell_x};

    // The RAM reads old data, so the write of the previous cycle is forwarded here.
    assign oldVal = (wrValid_q && (wrAddr_q == s1Addr_q)) ? wrData_q : ramRdData;
    assign newVal = sat_add(oldVal, s1Hit_q);

    assign rd_valid = rdValid_q;
    assign rd_data  = !rdValid_q ? '0
                    : (wrValid_q && (wrAddr_q == rdAddr_q)) ? wrData_q : ramRdData;

    occ_grid_ram u_ram (
        .clock     (clock),
        .rd_addr_i (ramRdAddr),
        .rd_data_o (ramRdData),
        .wr_en_i   (wrEn),
        .wr_addr_i (wrAddr),
        .wr_data_i (wrData)
    );

    // State register; reset always restarts the clear sweep.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: sweep to the last cell, run, and drain a pending write before clearing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR: if (clrAddr_q == '1) state_d = RUN;
            RUN:   if (clearReq) state_d = s1Valid_q ? DRAIN : CLEAR;
            DRAIN: state_d = CLEAR;
            default: state_d = CLEAR;
        endcase
    end

    // Outputs and write port: clear writes zeros, otherwise S1 writes its result.
    always_comb begin
        cell_ready = (state_q == RUN) && !rd_en;
        busy       = (state_q == CLEAR);
        wrEn       = 1'b0;
        wrAddr     = s1Addr_q;
        wrData     = newVal;
        unique case (state_q)
            CLEAR: begin
                wrEn   = reset_n;
                wrAddr = clrAddr_q;
                wrData = '0;
            end
            RUN, DRAIN: wrEn = reset_n & s1Valid_q;
            default: wrEn = 1'b0;
        endcase
    end

    // Clear sweep address, held at zero outside CLEAR so every sweep starts at cell 0.
    always_ff @(posedge clock) begin
        if (!reset_n || (state_q != CLEAR)) begin
            clrAddr_q <= '0;
        end else begin
            clrAddr_q <= clrAddr_q + cell_addr_t'(1);
        end
    end

    // S1 pipeline register capturing each accepted update.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1Valid_q <= 1'b0;
        end else begin
            s1Valid_q <= accept;
        end
        if (accept) begin
            s1Addr_q <= {cell_y, cell_x};
            s1Hit_q  <= cell_hit;
        end
    end

    // Remember last cycle's write for S1 and read-port forwarding.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wrValid_q <= 1'b0;
        end else begin
            wrValid_q <= wrEn;
        end
        wrAddr_q <= wrAddr;
        wrData_q <= wrData;
    end

    // External read tracking: valid and address one cycle behind rd_en.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rdValid_q <= 1'b0;
        end else begin
            rdValid_q <= rd_en;
        end
        rdAddr_q <= {rd_y, rd_x};
    end

`ifdef OCC_STATS_EN
    logic [31:0] statUpdates_q;
    logic [31:0] statSat_q;

    assign stat_updates = statUpdates_q;
    assign stat_sat     = statSat_q;

    // Free-running counters of accepted cells and of clamped S1 results.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            statUpdates_q <= '0;
            statSat_q     <= '0;
        end else begin
            if (accept) begin
                statUpdates_q <= statUpdates_q + 32'd1;
            end
            if (wrEn && (state_q != CLEAR) && sat_clamps(oldVal, s1Hit_q)) begin
                statSat_q <= statSat_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_occupancy_grid_updater.sv
// Self-checking bench for occupancy_grid_updater: directed scenarios plus a
// randomized phase, all compared against a plain array model of the map.
module tb_occupancy_grid_updater;
    import occ_grid_pkg::*;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             cell_valid;
    logic             cell_ready;
    logic [X_W-1:0]   cell_x;
    logic [Y_W-1:0]   cell_y;
    logic             cell_hit;
    logic             rd_en;
    logic [X_W-1:0]   rd_x;
    logic [Y_W-1:0]   rd_y;
    logic             rd_valid;
    log_odds_t        rd_data;
    logic             busy;
`ifdef OCC_STATS_EN
    logic [31:0]      stat_updates;
    logic [31:0]      stat_sat;
`endif

    int checkCount = 0;
    int errorCount = 0;
    int refMap [CELLS];
    int modelUpdates = 0;
    int modelSat = 0;
    bit lastAccepted;
    int lastRdData;

    always #5 clock = ~clock;

    occupancy_grid_updater dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cell_valid (cell_valid),
        .cell_ready (cell_ready),
        .cell_x     (cell_x),
        .cell_y     (cell_y),
        .cell_hit   (cell_hit),
        .rd_en      (rd_en),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .busy       (busy)
`ifdef OCC_STATS_EN
        ,
        .stat_updates (stat_updates),
        .stat_sat     (stat_sat)
`endif
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs from a negedge, update the model on a handshake,
    // and check the read result one cycle later when a read was issued.
    task automatic applyStimulus(input bit valid, input int x, input int y, input bit hit,
                                 input bit rd, input int rx, input int ry, input string tag);
        int readExp;
        int idx;
        int n;
        cell_valid = valid;
        cell_x     = x[X_W-1:0];
        cell_y     = y[Y_W-1:0];
        cell_hit   = hit;
        rd_en      = rd;
        rd_x       = rx[X_W-1:0];
        rd_y       = ry[Y_W-1:0];
        #1;
        readExp = refMap[ry * 256 + rx];
        lastAccepted = cell_valid && cell_ready;
        if (lastAccepted) begin
            idx = y * 256 + x;
            n = refMap[idx] + (hit ? 7 : -2);
            if (n > 100) begin
                n = 100;
                modelSat++;
            end else if (n < -100) begin
                n = -100;
                modelSat++;
            end
            refMap[idx] = n;
            modelUpdates++;
        end
        @(negedge clock);
        if (rd) begin
            lastRdData = int'($signed(rd_data));
            checkOutput({tag, "_valid"}, longint'(rd_valid), 1);
            checkOutput(tag, longint'($signed(rd_data)), longint'(readExp));
        end
    endtask

    // Idle one cycle with all requests low.
    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, "idle");
    endtask

    // Direct read with an explicitly supplied expectation (used while clearing).
    task automatic readCell(input int rx, input int ry, input string tag, input int expected);
        cell_valid = 0;
        rd_en = 1;
        rd_x  = rx[X_W-1:0];
        rd_y  = ry[Y_W-1:0];
        @(negedge clock);
        rd_en = 0;
        checkOutput({tag, "_valid"}, longint'(rd_valid), 1);
        checkOutput(tag, longint'($signed(rd_data)), longint'(expected));
    endtask

    initial begin
        int count;
        int readyLow;
        int prevVal;

        reset_n = 0;
        cell_valid = 0; cell_x = '0; cell_y = '0; cell_hit = 0;
        rd_en = 0; rd_x = '0; rd_y = '0;
        foreach (refMap[i]) refMap[i] = 0;

        // Reset values and full clear sweep
        repeat (3) @(negedge clock);
        checkOutput("rst_ready", longint'(cell_ready), 0);
        checkOutput("rst_busy", longint'(busy), 1);
        checkOutput("rst_rdValid", longint'(rd_valid), 0);
        checkOutput("rst_rdData", longint'($signed(rd_data)), 0);
`ifdef OCC_STATS_EN
        checkOutput("rst_statUpd", longint'(stat_updates), 0);
        checkOutput("rst_statSat", longint'(stat_sat), 0);
`endif
        reset_n = 1;
        count = 0;
        readyLow = 0;
        while (busy && count < 40000) begin
            if (cell_ready) readyLow++;
            count++;
            @(negedge clock);
        end
        checkOutput("clr_cycles", count, 32768);
        checkOutput("clr_readyDuringBusy", readyLow, 0);
        checkOutput("run_busy", longint'(busy), 0);
        checkOutput("run_ready", longint'(cell_ready), 1);
        checkOutput("run_rdValidIdle", longint'(rd_valid), 0);
        applyStimulus(0, 0, 0, 0, 1, 10, 5, "t1_read");
        checkOutput("t1_const", lastRdData, 0);

        // One hit then four frees at (3,4)
        applyStimulus(1, 3, 4, 1, 0, 0, 0, "t2");
        applyStimulus(0, 0, 0, 0, 1, 3, 4, "t2_hitRead");
        checkOutput("t2_hitConst", lastRdData, 7);
        repeat (4) applyStimulus(1, 3, 4, 0, 0, 0, 0, "t2");
        applyStimulus(0, 0, 0, 0, 1, 3, 4, "t2_freeRead");
        checkOutput("t2_freeConst", lastRdData, -1);

        // Twenty back-to-back hits at (0,0) saturate at the upper bound
        readyLow = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, 0, 1, 0, 0, 0, "t3");
            if (!lastAccepted) readyLow++;
        end
        checkOutput("t3_readyLow", readyLow, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, "t3_read");
        checkOutput("t3_const", lastRdData, 100);
`ifdef OCC_STATS_EN
        checkOutput("t3_statSat", longint'(stat_sat), 6);
        checkOutput("t3_statUpd", longint'(stat_updates), longint'(modelUpdates));
`endif

        // Sixty frees at the far corner pin at the lower bound, then one hit
        for (int i = 0; i < 60; i++) applyStimulus(1, 255, 127, 0, 0, 0, 0, "t4");
        applyStimulus(0, 0, 0, 0, 1, 255, 127, "t4_minRead");
        checkOutput("t4_minConst", lastRdData, -100);
        applyStimulus(1, 255, 127, 1, 0, 0, 0, "t4");
        applyStimulus(0, 0, 0, 0, 1, 255, 127, "t4_hitRead");
        checkOutput("t4_hitConst", lastRdData, -93);

        // A held read blocks updates; releasing it lets the update in
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 9, 9, 1, 1, 9, 9, "t5_blockRead");
            checkOutput("t5_blocked", longint'(lastAccepted), 0);
        end
        applyStimulus(1, 9, 9, 1, 0, 0, 0, "t5");
        checkOutput("t5_released", longint'(lastAccepted), 1);
        applyStimulus(0, 0, 0, 0, 1, 9, 9, "t5_read");
        checkOutput("t5_const", lastRdData, 7);

        // Bring (3,4) to 7, then read it in the same cycle as the write of 14
        applyStimulus(1, 3, 4, 1, 0, 0, 0, "t6");
        applyStimulus(1, 3, 4, 1, 0, 0, 0, "t6");
        repeat (3) applyStimulus(1, 3, 4, 0, 0, 0, 0, "t6");
        applyStimulus(0, 0, 0, 0, 1, 3, 4, "t6_pre");
        checkOutput("t6_preConst", lastRdData, 7);
        applyStimulus(1, 3, 4, 1, 0, 0, 0, "t6");
        applyStimulus(0, 0, 0, 0, 1, 3, 4, "t6_fwdRead");
        checkOutput("t6_fwdConst", lastRdData, 14);

        // Randomized traffic over a small hot region plus the saturated corner
        for (int i = 0; i < 1500; i++) begin
            int x;
            int y;
            bit v;
            bit r;
            if ($urandom_range(0, 7) == 0) begin
                x = 255; y = 127;
            end else begin
                x = $urandom_range(0, 3); y = $urandom_range(0, 1);
            end
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) == 0);
            applyStimulus(v, x, y, $urandom_range(0, 1) == 1, r,
                          $urandom_range(0, 3), $urandom_range(0, 1), "rand_read");
        end
        idleCycle();
        idleCycle();
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                applyStimulus(0, 0, 0, 0, 1, x, y, "final_read");
`ifdef OCC_STATS_EN
        checkOutput("final_statUpd", longint'(stat_updates), longint'(modelUpdates));
        checkOutput("final_statSat", longint'(stat_sat), longint'(modelSat));
`endif

        // Reset while an update sits in S1: its write is lost and the sweep restarts
        prevVal = refMap[1 * 256 + 0];
        cell_valid = 1; cell_x = 8'd0; cell_y = 7'd1; cell_hit = 1; rd_en = 0;
        #1;
        checkOutput("t7_accept", longint'(cell_ready), 1);
        @(negedge clock);
        cell_valid = 0;
        reset_n = 0;
        @(negedge clock);
        checkOutput("t7_busy", longint'(busy), 1);
        checkOutput("t7_ready", longint'(cell_ready), 0);
        checkOutput("t7_rdValid", longint'(rd_valid), 0);
        reset_n = 1;
        repeat (4) @(negedge clock);
        checkOutput("t7_stillBusy", longint'(busy), 1);
        readCell(0, 0, "t7_sweptZero", 0);
        readCell(0, 1, "t7_s1Dropped", prevVal);
        readCell(3, 4, "t7_unswept", refMap[4 * 256 + 3]);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
